// File: rtl/gpio_input_debounce_pkg.sv
// gpio_input_debounce_pkg
//   Shared constants for the board GPIO input conditioning path: default
//   debounce timing, board input width and the position of each button and
//   switch inside the conditioned vector {dir_btns[4:0], gpio_sws[7:0]}.
//   No ports; imported by gpio_input_debounce and gpio_input_debounce_bit.
package gpio_input_debounce_pkg;

   localparam int GPIO_WIDTH       = 13;
   localparam int DEF_TICK_CYCLES  = 50000;   // 1 ms at 50 MHz
   localparam int DEF_STABLE_TICKS = 10;

   // Switches occupy the low byte, direction buttons the top five bits.
   localparam int SW_LSB_IDX = 0;
   localparam int SW_MSB_IDX = 7;
   localparam int BTN_W_IDX  = 8;
   localparam int BTN_S_IDX  = 9;
   localparam int BTN_N_IDX  = 10;
   localparam int BTN_E_IDX  = 11;
   localparam int BTN_C_IDX  = 12;

   // Width needed to hold 0..stable_ticks inclusive, never less than 1 bit.
   function automatic int stable_cnt_width(input int stable_ticks);
      int w;
      w = $clog2(stable_ticks + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/gpio_input_debounce_bit.sv
// gpio_input_debounce_bit
//   One conditioned input: 2-flop synchronizer, tick-gated stability counter,
//   debounced level flop and registered one-cycle rise/fall pulses.
// Ports
//   clk        in   CPU clock
//   reset_n    in   asynchronous reset, active-low
//   raw        in   asynchronous pad input
//   tick       in   shared debounce tick (one clk cycle wide)
//   db         out  debounced level
//   rise       out  one-cycle pulse, the cycle after db goes 0->1
//   fall       out  one-cycle pulse, the cycle after db goes 1->0
module gpio_input_debounce_bit
   import gpio_input_debounce_pkg::*;
#(
   parameter int   STABLE_TICKS = DEF_STABLE_TICKS,
   parameter logic RESET_VAL    = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   input  logic tick,
   output logic db,
   output logic rise,
   output logic fall
);

   localparam int CNT_W = stable_cnt_width(STABLE_TICKS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

   logic             s1;
   logic             s2;
   logic             db_d;
   logic [CNT_W-1:0] cnt;

   // db_d resets to the same value as db so reset never looks like an edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1   <= RESET_VAL;
         s2   <= RESET_VAL;
         db   <= RESET_VAL;
         db_d <= RESET_VAL;
         cnt  <= '0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         s1   <= raw;
         s2   <= s1;
         db_d <= db;
         rise <= db & ~db_d;
         fall <= ~db & db_d;
         if (s2 == db) begin
            cnt <= '0;
         end else if (tick) begin
            if (cnt == CNT_LAST) begin
               db  <= ~db;
               cnt <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/gpio_input_debounce.sv
// gpio_input_debounce
//   Conditions the board buttons and DIP switches before they reach the CPU
//   gpioA_in port. Holds the shared debounce prescaler and the sticky,
//   maskable change-interrupt; per-bit conditioning lives in
//   gpio_input_debounce_bit.
// Ports
//   clk          in   CPU clock (50 MHz)
//   reset_n      in   asynchronous reset, active-low
//   raw_in       in   WIDTH asynchronous pad inputs
//   db_out       out  WIDTH debounced levels (drive gpioA_in)
//   rise_pulse   out  WIDTH one-cycle 0->1 pulses
//   fall_pulse   out  WIDTH one-cycle 1->0 pulses
//   irq_mask     in   WIDTH edge enables for the pending flags
//   irq_clear    in   WIDTH write-one-to-clear for the pending flags
//   irq_pending  out  WIDTH sticky edge flags
//   irq          out  registered OR of irq_pending
module gpio_input_debounce
   import gpio_input_debounce_pkg::*;
#(
   parameter int               WIDTH        = GPIO_WIDTH,
   parameter int               TICK_CYCLES  = DEF_TICK_CYCLES,
   parameter int               STABLE_TICKS = DEF_STABLE_TICKS,
   parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] raw_in,
   output logic [WIDTH-1:0] db_out,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse,
   input  logic [WIDTH-1:0] irq_mask,
   input  logic [WIDTH-1:0] irq_clear,
   output logic [WIDTH-1:0] irq_pending,
   output logic             irq
);

   localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);

   logic [PRE_W-1:0] pre_cnt;
   logic             tick;
   logic [WIDTH-1:0] edge_hit;

   assign tick = (pre_cnt == PRE_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_cnt <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + PRE_W'(1);
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      gpio_input_debounce_bit #(
         .STABLE_TICKS (STABLE_TICKS),
         .RESET_VAL    (RESET_VAL[i])
      ) u_bit (
         .clk     (clk),
         .reset_n (reset_n),
         .raw     (raw_in[i]),
         .tick    (tick),
         .db      (db_out[i]),
         .rise    (rise_pulse[i]),
         .fall    (fall_pulse[i])
      );
   end

   assign edge_hit = (rise_pulse | fall_pulse) & irq_mask;

   // A new edge in the same cycle as a clear keeps the flag set so no event
   // is lost between software reading and acknowledging it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_pending <= '0;
         irq         <= 1'b0;
      end else begin
         irq_pending <= (irq_pending & ~irq_clear) | edge_hit;
         irq         <= |irq_pending;
      end
   end

endmodule
